// File: rtl/strip_sequencer_if.sv
// Command channel from strip_sequencer to a downstream LED pixel driver.
interface strip_sequencer_if;
   logic        out_valid;
   logic        out_reset;
   logic [23:0] out_color;
   logic        in_ready;

   // A command transfers in a cycle with out_valid && in_ready. Until then the
   // master holds out_valid, out_reset and out_color stable and never retracts.
   modport master (output out_valid, output out_reset, output out_color, input in_ready);
   modport slave  (input out_valid, input out_reset, input out_color, output in_ready);
endinterface

// File: rtl/strip_sequencer.sv
// Pixel-strip frame sequencer: one latch/reset command, then every RAM pixel in order.
// Optional macro STRIP_BRIGHTNESS_EN scales each colour byte by (brightness+1)/256.
module strip_sequencer #(
   parameter int NUM_PIXELS = 64,
   parameter int ADDR_BITS  = 6
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [23:0]          wr_data,
   input  logic                 start,
   input  logic [7:0]           brightness,
   strip_sequencer_if.master    cmd,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           dbg_state
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND_RST = 2'd1,
      FETCH    = 2'd2,
      SEND_PIX = 2'd3
   } state_t;

   localparam int unsigned          NUM_PIX_U = NUM_PIXELS;
   localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(NUM_PIXELS - 1);

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   idx_q, idx_d;
   logic                   valid_q, valid_d;
   logic                   rst_cmd_q, rst_cmd_d;
   logic [23:0]            color_q, color_d;
   logic [23:0]            rd_word;
   logic [23:0]            rd_color;

   // Depth spans the address space so any index is legal; only the first
   // NUM_PIXELS entries are ever written or read.
   logic [23:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (wr_en && (32'(wr_addr) < NUM_PIX_U)) mem[wr_addr] <= wr_data;
   end

   // color_q is the RAM output register, so a same-cycle write yields old data.
   assign rd_word = mem[idx_q];

`ifdef STRIP_BRIGHTNESS_EN
   function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
      logic [8:0]  b1;
      logic [16:0] p;
      b1 = {1'b0, b} + 9'd1;
      p  = 17'(c) * 17'(b1);
      return p[15:8];
   endfunction

   assign rd_color = {scale8(rd_word[23:16], brightness),
                      scale8(rd_word[15:8],  brightness),
                      scale8(rd_word[7:0],   brightness)};
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign rd_color          = rd_word;
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      rst_cmd_d = rst_cmd_q;
      color_d   = color_q;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SEND_RST;
               valid_d   = 1'b1;
               rst_cmd_d = 1'b1;
               color_d   = '0;
            end
         end
         SEND_RST: begin
            if (cmd.in_ready) begin
               state_d   = FETCH;
               idx_d     = '0;
               valid_d   = 1'b0;
               rst_cmd_d = 1'b0;
            end
         end
         FETCH: begin
            state_d = SEND_PIX;
            valid_d = 1'b1;
            color_d = rd_color;
         end
         SEND_PIX: begin
            if (cmd.in_ready) begin
               valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  done    = 1'b1;
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         rst_cmd_q <= 1'b0;
         color_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         rst_cmd_q <= rst_cmd_d;
         color_q   <= color_d;
      end
   end

   assign cmd.out_valid = valid_q;
   assign cmd.out_reset = rst_cmd_q;
   assign cmd.out_color = color_q;
   assign busy          = (state_q != IDLE);
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_strip_sequencer.sv
// Self-checking bench for strip_sequencer: frames compared against a command-list model.
module tb_strip_sequencer;
   localparam int NPIX = 4;
   localparam int AB   = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AB-1:0] wr_addr = '0;
   logic [23:0]   wr_data = '0;
   logic          start = 1'b0;
   logic [7:0]    brightness = 8'd255;
   logic          busy, done;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   strip_sequencer_if cmd_if ();

   strip_sequencer #(.NUM_PIXELS(NPIX), .ADDR_BITS(AB)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .brightness(brightness), .cmd(cmd_if), .busy(busy), .done(done),
      .dbg_state(dbg_state)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [23:0] model_ram [NPIX];
   logic [24:0] exp_q[$];
   logic [24:0] got_q[$];
   int done_cnt, done_off, busy_low, stall_err, stall_cycles, first_valid_c, wr_hits;
   bit timed_out;

   function automatic logic [23:0] expect_color(input logic [23:0] w, input logic [7:0] b);
`ifdef STRIP_BRIGHTNESS_EN
      logic [23:0] r;
      for (int k = 0; k < 3; k++) r[k*8 +: 8] = 8'((int'(w[k*8 +: 8]) * (int'(b) + 1)) / 256);
      return r;
`else
      return w;
`endif
   endfunction

   // A frame is one reset command followed by every pixel in address order.
   task automatic build_exp();
      exp_q.delete();
      exp_q.push_back({1'b1, 24'h000000});
      for (int i = 0; i < NPIX; i++) exp_q.push_back({1'b0, expect_color(model_ram[i], brightness)});
   endtask

   task automatic do_write(input logic [AB-1:0] a, input logic [23:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      if (int'(a) < NPIX) model_ram[a] = d;
   endtask

   // Starts a frame and records every accepted command until done or max_cyc.
   // rdy_mode: 0 always ready, 1 random ready, 2 ten-cycle stall on pixel 1.
   task automatic collect(input int max_cyc, input int rdy_mode, input bit start_mid,
                          input bit start_on_done, input bit wr_in_fetch);
      bit hold = 1'b0;
      bit seen_done = 1'b0;
      bit stalled = 1'b0;
      int stall_left = 0;
      logic [24:0] held = '0;
      got_q.delete();
      done_cnt = 0; done_off = 0; busy_low = 0; stall_err = 0; stall_cycles = 0;
      first_valid_c = -1; wr_hits = 0; timed_out = 1'b0;
      for (int c = 0; c < max_cyc && !seen_done; c++) begin
         @(negedge clk);
         if (hold && (cmd_if.out_valid !== 1'b1 || {cmd_if.out_reset, cmd_if.out_color} !== held))
            stall_err++;
         if (c > 0 && busy !== 1'b1) busy_low++;
         if (first_valid_c < 0 && cmd_if.out_valid === 1'b1) first_valid_c = c;
         start = (c == 0) || (start_mid && c == 5);
         wr_en = 1'b0;
         if (wr_in_fetch && wr_hits == 0 && c > 0 && busy && !cmd_if.out_valid && got_q.size() == 3) begin
            wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'hABCDEF;
            model_ram[2] = 24'hABCDEF;
            wr_hits++;
         end
         case (rdy_mode)
            0: cmd_if.in_ready = 1'b1;
            1: cmd_if.in_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (!stalled && cmd_if.out_valid && !cmd_if.out_reset && got_q.size() == 2) begin
                  stalled = 1'b1; stall_left = 10;
               end
               if (stall_left > 0) begin
                  cmd_if.in_ready = 1'b0;
                  stall_left--;
                  if (cmd_if.out_valid === 1'b1 && cmd_if.out_color === 24'h00FF00) stall_cycles++;
               end else cmd_if.in_ready = 1'b1;
            end
         endcase
         #1;
         if (cmd_if.out_valid && cmd_if.in_ready) got_q.push_back({cmd_if.out_reset, cmd_if.out_color});
         if (done === 1'b1) begin
            done_cnt++;
            seen_done = 1'b1;
            if (!(cmd_if.out_valid && cmd_if.in_ready && got_q.size() == NPIX + 1)) done_off++;
            if (start_on_done) start = 1'b1;
         end
         hold = cmd_if.out_valid && !cmd_if.in_ready;
         held = {cmd_if.out_reset, cmd_if.out_color};
      end
      if (!seen_done) timed_out = 1'b1;
      if (start_on_done || !seen_done) begin
         @(negedge clk);
         start = 1'b0; wr_en = 1'b0;
      end
      cmd_if.in_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp += 6;
      if (cmd_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", cmd_if.out_valid); end
      if (cmd_if.out_reset !== 1'b0) begin n_bad++; $display("FAIL reset_rst: got %b want 0", cmd_if.out_reset); end
      if (cmd_if.out_color !== 24'h0) begin n_bad++; $display("FAIL reset_color: got %h want 0", cmd_if.out_color); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      reset_n = 1'b1;
   endtask

   task automatic test_basic_frame();
      do_write(3'd0, 24'hFF0000); do_write(3'd1, 24'h00FF00);
      do_write(3'd2, 24'h0000FF); do_write(3'd3, 24'h123456);
      brightness = 8'd255;
      build_exp();
      collect(100, 0, 1'b0, 1'b0, 1'b0);
      n_cmp += 6;
      if (timed_out) begin n_bad++; $display("FAIL basic_timeout: no done within budget"); end
      if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_cmd%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      if (done_cnt != 1 || done_off != 0) begin n_bad++; $display("FAIL basic_done: got %0d pulses %0d misaligned want 1/0", done_cnt, done_off); end
      if (busy_low != 0) begin n_bad++; $display("FAIL basic_busy: got %0d low cycles want 0", busy_low); end
      if (first_valid_c != 1) begin n_bad++; $display("FAIL basic_latency: got cycle %0d want 1", first_valid_c); end
      if (got_q.size() > 4 && got_q[4] !== {1'b0, 24'h123456}) begin n_bad++; $display("FAIL basic_last: got %h want 0123456", got_q[4]); end
   endtask

   task automatic test_stall();
      build_exp();
      collect(200, 2, 1'b0, 1'b0, 1'b0);
      n_cmp += 4;
      if (timed_out || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_cmd%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      if (stall_cycles != 10) begin n_bad++; $display("FAIL stall_hold: got %0d held cycles want 10", stall_cycles); end
      if (stall_err != 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_err); end
      if (done_cnt != 1) begin n_bad++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_start_ignored();
      int extra = 0;
      build_exp();
      collect(100, 0, 1'b1, 1'b1, 1'b0);
      n_cmp += 2;
      if (timed_out || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ignore_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ignore_cmd%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      repeat (20) begin
         @(negedge clk);
         if (cmd_if.out_valid !== 1'b0 || busy !== 1'b0) extra++;
      end
      if (extra != 0) begin n_bad++; $display("FAIL ignore_restart: got %0d active cycles want 0", extra); end
   endtask

   task automatic test_back_to_back();
      build_exp();
      for (int f = 0; f < 2; f++) begin
         collect(100, 0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if (timed_out || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count%0d: got %0d want %0d", f, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_cmd%0d_%0d: got %h want %h", f, i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_midframe();
      int seen = 0;
      int extra = 0;
      bit found = 1'b0;
      @(negedge clk);
      start = 1'b1; cmd_if.in_ready = 1'b1;
      for (int c = 0; c < 60 && !found; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (cmd_if.out_valid && !cmd_if.out_reset && seen == 3) found = 1'b1;
         else if (cmd_if.out_valid) seen++;
      end
      n_cmp += 4;
      if (!found) begin n_bad++; $display("FAIL midrst_reach: pixel 2 not reached, got %0d commands", seen); end
      cmd_if.in_ready = 1'b0;
      reset_n = 1'b0;
      #1;
      if (cmd_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", cmd_if.out_valid); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      @(negedge clk);
      reset_n = 1'b1; cmd_if.in_ready = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (cmd_if.out_valid !== 1'b0 || busy !== 1'b0) extra++;
      end
      if (extra != 0) begin n_bad++; $display("FAIL midrst_resume: got %0d active cycles want 0", extra); end
      build_exp();
      collect(100, 0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (timed_out || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL midrst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL midrst_cmd%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_write_during_fetch();
      do_write(3'd2, 24'h0000FF);
      build_exp();
      collect(100, 0, 1'b0, 1'b0, 1'b1);
      n_cmp += 2;
      if (wr_hits != 1) begin n_bad++; $display("FAIL wrfetch_hit: got %0d writes want 1", wr_hits); end
      if (got_q.size() != exp_q.size() || got_q[3] !== {1'b0, 24'h0000FF}) begin
         n_bad++; $display("FAIL wrfetch_old: got %0d cmds, pix2 %h want 00000ff", got_q.size(), got_q.size() > 3 ? got_q[3] : 25'h0);
      end
      build_exp();
      collect(100, 0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (got_q.size() != exp_q.size() || got_q[3] !== {1'b0, 24'hABCDEF}) begin
         n_bad++; $display("FAIL wrfetch_new: got %0d cmds, pix2 %h want 0abcdef", got_q.size(), got_q.size() > 3 ? got_q[3] : 25'h0);
      end
   endtask

   task automatic test_brightness();
      logic [23:0] want;
      do_write(3'd0, 24'hFF8001);
      for (int k = 0; k < 2; k++) begin
         brightness = (k == 0) ? 8'd127 : 8'd255;
`ifdef STRIP_BRIGHTNESS_EN
         want = (k == 0) ? 24'h7F4000 : 24'hFF8001;
`else
         want = 24'hFF8001;
`endif
         build_exp();
         collect(100, 0, 1'b0, 1'b0, 1'b0);
         n_cmp += 2;
         if (got_q.size() < 2 || got_q[1] !== {1'b0, want}) begin
            n_bad++; $display("FAIL bright%0d: got %h want %h", brightness, got_q.size() > 1 ? got_q[1] : 25'h0, want);
         end
         if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bright_count: got %0d want %0d", got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bright_cmd%0d: got %h want %h", i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++) begin
         repeat (6) do_write(3'($urandom_range(0, 7)), 24'($urandom));
         brightness = 8'($urandom_range(0, 255));
         build_exp();
         collect(300, 1, 1'b0, 1'b0, 1'b0);
         n_cmp += 2;
         if (timed_out || got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count%0d: got %0d want %0d", f, got_q.size(), exp_q.size()); end
         if (stall_err != 0) begin n_bad++; $display("FAIL rand_stable%0d: got %0d changes want 0", f, stall_err); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_cmd%0d_%0d: got %h want %h", f, i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      cmd_if.in_ready = 1'b1;
      test_reset();
      test_basic_frame();
      test_stall();
      test_start_ignored();
      test_back_to_back();
      test_reset_midframe();
      test_write_during_fetch();
      test_brightness();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
